ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

EX/MEM pipeline stage of the 5-stage 64-bit RISC-V core, directly downstream of the 64-bit ALU. It registers the ALU `Result`/`ZERO` pair together with store data, destination register and MEM/WB control bits. It resolves conditional branches in the MEM cycle, where taken = branch & ZERO, which covers both BEQ and BLT. It also generates the PC redirect and the flush of the younger wrong-path instructions.

## Interface
Parameters:
- `XLEN`, 64: datapath width.
- `REG_AW`, 5: register index width.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `ex_valid` in 1: EX holds a real instruction.
- `ex_result` in XLEN: ALU `Result`.
- `ex_zero` in 1: ALU `ZERO`.
- `ex_pc` in XLEN: PC of the EX instruction.
- `ex_imm` in XLEN: sign-extended branch immediate, in halfword units.
- `ex_rs2_data` in XLEN: store data.
- `ex_rd` in REG_AW: destination register.
- `ex_branch`, `ex_mem_read`, `ex_mem_write`, `ex_reg_write`, `ex_mem_to_reg` in 1 each: control bits.
- `stall` in 1: hold the stage.
- `flush` in 1: external squash, e.g. trap.
- `mem_valid`, `mem_result`, `mem_rs2_data`, `mem_rd`, `mem_mem_read`, `mem_mem_write`, `mem_reg_write`, `mem_mem_to_reg` out: registered copies of the EX inputs.
- `branch_target` out XLEN: registered target.
- `pc_src` out 1: redirect IF to `branch_target`.
- `flush_out` out 1: squash IF/ID and ID/EX.
- `stat_retired`, `stat_taken` out 32 each: event counters.

## Operation
- **Reset:** a cycle with `reset_n`=0 at the edge clears every registered output and both counters to 0.
- **Capture priority at each edge:** reset > `flush` > `stall` > bubble > normal.
  - `flush`=1: load a bubble (see below), even if `stall`=1.
  - `stall`=1, no flush: every register holds, including `branch_target` and the taken flag.
  - `pc_src`=1, no stall: the instruction arriving from EX is wrong-path and is loaded as a bubble.
  - Otherwise: load all EX inputs.
- **Bubble contents:** `mem_valid`, `mem_reg_write`, `mem_mem_write`, `mem_mem_read`, `mem_mem_to_reg` and the internal taken flag are 0. Data fields (`mem_result`, `mem_rs2_data`, `mem_rd`) load normally; they are don't-care.
- **Branch target:** `ex_pc + (ex_imm << 1)`, modulo 2^XLEN (wrap-around, no overflow flag), registered with the instruction.
- **Taken flag:** registered value of `ex_valid & ex_branch & ex_zero`.
- **`pc_src` / `flush_out`:** both equal the registered taken flag; they are not combinational from EX inputs.
- **Stall during a redirect:** if `stall`=1 while `pc_src`=1, `pc_src` stays high for the whole stall. IF must accept a held redirect.
- **Flush during a redirect:** an external `flush` in the same cycle as `pc_src`=1 discards the redirect; the trap owns the next PC.

## Timing
- Latency is exactly 1 cycle from the EX inputs to the `mem_*` outputs, `branch_target` and `pc_src`.
- `pc_src` is high for exactly one cycle per taken branch when there is no stall. The bubble loaded that cycle clears the flag on the next edge.
- There is no combinational path from any input to any output except the `stat_*` tie-offs.

## Configuration
- `EXMEM_STATS_EN` defined:
  - `stat_retired` increments on every non-stalled edge that loads `ex_valid`=1, excluding bubbles.
  - `stat_taken` increments on the edge that loads a taken flag of 1.
  - Both are 32-bit, wrap from 0xFFFF_FFFF to 0, and are cleared by reset; neither counts while `stall`=1.
- Undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- Shared package `riscv_pkg`:
  - `XLEN`, `REG_AW`.
  - ALU op encodings: AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100, BLT 1000, ADDI 1001, SLLI 1111.
  - Packed struct `mem_ctl_t` for the five control bits, reused by the ID/EX and MEM/WB stages.
- One sub-module, `ex_mem_branch_resolve`:
  - Combinational taken and target computation.
  - Instantiated once; the register bank stays in the top module.

## Test plan
- **Reset:** drive all inputs to 1s with `reset_n`=0 for 2 cycles -> every output reads 0, `stat_*` read 0.
- **Pass-through:** `ex_result`=0x1234, `ex_rd`=5, `ex_reg_write`=1, `ex_valid`=1 -> next cycle `mem_result`=0x1234, `mem_rd`=5, `mem_reg_write`=1, `pc_src`=0.
- **Taken BLT:** `ex_branch`=1, `ex_zero`=1, `ex_pc`=0x100, `ex_imm`=0x10 -> next cycle `pc_src`=`flush_out`=1, `branch_target`=0x120. The following ADD is loaded with `mem_valid`=0 and `mem_reg_write`=0, and `pc_src` returns to 0 one cycle later.
- **Not taken / wrap:** `ex_branch`=1, `ex_zero`=0 -> `pc_src` stays 0. Separately, `ex_pc`=0xFFFF_FFFF_FFFF_FFF0 with `ex_imm`=0x10 -> `branch_target`=0x10.
- **Stall/flush:** `stall`=1 for 3 cycles while the inputs change -> outputs frozen, and an active `pc_src` stays 1. `stall`=1 and `flush`=1 together -> a bubble is loaded and `pc_src` drops.
- **Stats (`EXMEM_STATS_EN`):** 4 valid instructions, one of them taken, one cycle stalled -> `stat_retired`=3, with the taken branch's wrong-path successor loaded as a bubble, and `stat_taken`=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage 64-bit RISC-V core: datapath widths,
// ALU operation encodings and the pipelined memory/writeback control bundle.
package riscv_pkg;

   localparam int XLEN   = 64;
   localparam int REG_AW = 5;

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SUB  = 4'b0110,
      ALU_NOR  = 4'b1100,
      ALU_BLT  = 4'b1000,
      ALU_ADDI = 4'b1001,
      ALU_SLLI = 4'b1111
   } alu_op_t;

   // Control bits carried from ID/EX through MEM/WB. In the MEM stage the
   // branch bit holds the resolved outcome (taken) rather than the raw opcode bit.
   typedef struct packed {
      logic branch;
      logic mem_read;
      logic mem_write;
      logic reg_write;
      logic mem_to_reg;
   } mem_ctl_t;

endpackage

// File: rtl/ex_mem_branch_resolve.sv
// Combinational branch resolution for the EX/MEM stage: taken decision from the
// ALU ZERO flag and the PC-relative target (immediate counted in halfwords).
module ex_mem_branch_resolve #(
   parameter int XLEN = riscv_pkg::XLEN
) (
   input  logic            valid,
   input  logic            branch,
   input  logic            zero,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   output logic            taken,
   output logic [XLEN-1:0] target
);

   // BEQ and BLT both arrange for ZERO=1 when the branch should be taken.
   assign taken  = valid & branch & zero;
   // Sum is truncated to XLEN bits, so the target wraps modulo 2^XLEN.
   assign target = pc + (imm << 1);

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution, PC redirect and flush of
// younger wrong-path instructions. Optional event counters are built when
// EXMEM_STATS_EN is defined; otherwise stat_retired/stat_taken read 0.
module ex_mem_stage
   import riscv_pkg::*;
#(
   parameter int XLEN   = riscv_pkg::XLEN,
   parameter int REG_AW = riscv_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ex_valid,
   input  logic [XLEN-1:0]   ex_result,
   input  logic              ex_zero,
   input  logic [XLEN-1:0]   ex_pc,
   input  logic [XLEN-1:0]   ex_imm,
   input  logic [XLEN-1:0]   ex_rs2_data,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_branch,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic              ex_reg_write,
   input  logic              ex_mem_to_reg,
   input  logic              stall,
   input  logic              flush,
   output logic              mem_valid,
   output logic [XLEN-1:0]   mem_result,
   output logic [XLEN-1:0]   mem_rs2_data,
   output logic [REG_AW-1:0] mem_rd,
   output logic              mem_mem_read,
   output logic              mem_mem_write,
   output logic              mem_reg_write,
   output logic              mem_mem_to_reg,
   output logic [XLEN-1:0]   branch_target,
   output logic              pc_src,
   output logic              flush_out,
   output logic [31:0]       stat_retired,
   output logic [31:0]       stat_taken
);

   mem_ctl_t        ex_ctl;
   mem_ctl_t        ld_ctl;
   mem_ctl_t        ctl_q;
   logic            ex_taken;
   logic [XLEN-1:0] ex_target;
   logic            bubble;

   assign ex_ctl = '{branch:     ex_branch,
                     mem_read:   ex_mem_read,
                     mem_write:  ex_mem_write,
                     reg_write:  ex_reg_write,
                     mem_to_reg: ex_mem_to_reg};

   ex_mem_branch_resolve #(.XLEN(XLEN)) u_resolve (
      .valid  (ex_valid),
      .branch (ex_ctl.branch),
      .zero   (ex_zero),
      .pc     (ex_pc),
      .imm    (ex_imm),
      .taken  (ex_taken),
      .target (ex_target)
   );

   // Control word loaded for a real instruction: branch bit replaced by the outcome.
   always_comb begin
      // NOTE: assign every field a default first so no path leaves ld_ctl unassigned (no latch).
      ld_ctl        = ex_ctl;
      ld_ctl.branch = ex_taken;
   end

   // A held redirect or an external squash turns the incoming slot into a bubble.
   assign bubble = flush | ctl_q.branch;

   // Stage register: reset > flush > stall > bubble > normal load.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!reset_n) begin
         // NOTE: data registers are reset too, since every registered output must read 0 after reset.
         mem_valid     <= 1'b0;
         mem_result    <= '0;
         mem_rs2_data  <= '0;
         mem_rd        <= '0;
         branch_target <= '0;
         ctl_q         <= '0;
      end else if (flush || !stall) begin
         mem_result    <= ex_result;
         mem_rs2_data  <= ex_rs2_data;
         mem_rd        <= ex_rd;
         branch_target <= ex_target;
         if (bubble) begin
            mem_valid <= 1'b0;
            ctl_q     <= '0;
         end else begin
            mem_valid <= ex_valid;
            ctl_q     <= ld_ctl;
         end
      end
   end

   assign mem_mem_read   = ctl_q.mem_read;
   assign mem_mem_write  = ctl_q.mem_write;
   assign mem_reg_write  = ctl_q.reg_write;
   assign mem_mem_to_reg = ctl_q.mem_to_reg;
   assign pc_src         = ctl_q.branch;
   assign flush_out      = ctl_q.branch;

`ifdef EXMEM_STATS_EN
   logic        advance;
   logic [31:0] retired_q;
   logic [31:0] taken_q;

   // Only edges that load a real EX instruction count.
   assign advance = !stall && !bubble;

   // Free-running event counters, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         retired_q <= '0;
         taken_q   <= '0;
      end else begin
         if (advance && ex_valid) retired_q <= retired_q + 32'd1;
         if (advance && ex_taken) taken_q   <= taken_q + 32'd1;
      end
   end

   assign stat_retired = retired_q;
   assign stat_taken   = taken_q;
`else
   assign stat_retired = 32'd0;
   assign stat_taken   = 32'd0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed vectors push hand-computed
// expected outputs; a monitor pops and compares one entry per cycle.
module tb_ex_mem_stage;

`ifdef EXMEM_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      logic        reset_n, valid, zero, branch, mr, mw, rw, m2r, stall, flush;
      logic [63:0] result, pc, imm, rs2;
      logic [4:0]  rd;
   } in_t;

   typedef struct {
      logic        valid, mr, mw, rw, m2r, pc_src;
      logic [63:0] result, rs2, target;
      logic [4:0]  rd;
      logic [31:0] retired, taken;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n, ex_valid, ex_zero, ex_branch, ex_mem_read, ex_mem_write;
   logic        ex_reg_write, ex_mem_to_reg, stall, flush;
   logic [63:0] ex_result, ex_pc, ex_imm, ex_rs2_data;
   logic [4:0]  ex_rd;
   logic        mem_valid, mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg;
   logic        pc_src, flush_out;
   logic [63:0] mem_result, mem_rs2_data, branch_target;
   logic [4:0]  mem_rd;
   logic [31:0] stat_retired, stat_taken;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   in_t  vi;
   exp_t ve;

   always #5 clk = ~clk;

   ex_mem_stage dut (
      .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_result(ex_result),
      .ex_zero(ex_zero), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs2_data(ex_rs2_data),
      .ex_rd(ex_rd), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
      .ex_mem_to_reg(ex_mem_to_reg), .stall(stall), .flush(flush),
      .mem_valid(mem_valid), .mem_result(mem_result), .mem_rs2_data(mem_rs2_data),
      .mem_rd(mem_rd), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
      .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
      .branch_target(branch_target), .pc_src(pc_src), .flush_out(flush_out),
      .stat_retired(stat_retired), .stat_taken(stat_taken)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   function automatic in_t nop();
      in_t t;
      t = '{reset_n: 1'b1, valid: 1'b0, zero: 1'b0, branch: 1'b0, mr: 1'b0,
            mw: 1'b0, rw: 1'b0, m2r: 1'b0, stall: 1'b0, flush: 1'b0,
            result: 64'h0, pc: 64'h0, imm: 64'h0, rs2: 64'h0, rd: 5'd0};
      return t;
   endfunction

   function automatic exp_t ezero();
      exp_t t;
      t = '{valid: 1'b0, mr: 1'b0, mw: 1'b0, rw: 1'b0, m2r: 1'b0, pc_src: 1'b0,
            result: 64'h0, rs2: 64'h0, target: 64'h0, rd: 5'd0,
            retired: 32'd0, taken: 32'd0};
      return t;
   endfunction

   // Expected counter value: the count when the counters are built, else 0.
   function automatic logic [31:0] st(input logic [31:0] v);
      return STATS ? v : 32'd0;
   endfunction

   task automatic step(input in_t i, input exp_t e);
      @(negedge clk);
      reset_n = i.reset_n;  ex_valid = i.valid;   ex_zero = i.zero;
      ex_branch = i.branch; ex_mem_read = i.mr;   ex_mem_write = i.mw;
      ex_reg_write = i.rw;  ex_mem_to_reg = i.m2r;
      stall = i.stall;      flush = i.flush;
      ex_result = i.result; ex_pc = i.pc;         ex_imm = i.imm;
      ex_rs2_data = i.rs2;  ex_rd = i.rd;
      @(posedge clk);
      #1;
      exp_q.push_back(e);
   endtask

   // Monitor: outputs are registered, so sample each cycle on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("mem_valid",      mem_valid,      e.valid);
            check("mem_result",     mem_result,     e.result);
            check("mem_rs2_data",   mem_rs2_data,   e.rs2);
            check("mem_rd",         mem_rd,         e.rd);
            check("mem_mem_read",   mem_mem_read,   e.mr);
            check("mem_mem_write",  mem_mem_write,  e.mw);
            check("mem_reg_write",  mem_reg_write,  e.rw);
            check("mem_mem_to_reg", mem_mem_to_reg, e.m2r);
            check("branch_target",  branch_target,  e.target);
            check("pc_src",         pc_src,         e.pc_src);
            check("flush_out",      flush_out,      e.pc_src);
            check("stat_retired",   stat_retired,   e.retired);
            check("stat_taken",     stat_taken,     e.taken);
         end
      end
   end

   initial begin
      // Reset with every input driven high, two cycles.
      vi = '{reset_n: 1'b0, valid: 1'b1, zero: 1'b1, branch: 1'b1, mr: 1'b1,
             mw: 1'b1, rw: 1'b1, m2r: 1'b1, stall: 1'b1, flush: 1'b1,
             result: '1, pc: '1, imm: '1, rs2: '1, rd: '1};
      ve = ezero();
      step(vi, ve);
      step(vi, ve);

      // Pass-through ALU op.
      vi = nop(); vi.valid = 1; vi.result = 64'h1234; vi.rd = 5; vi.rw = 1; vi.rs2 = 64'hBEEF;
      ve = ezero(); ve.valid = 1; ve.result = 64'h1234; ve.rd = 5; ve.rw = 1; ve.rs2 = 64'hBEEF;
      ve.retired = st(1);
      step(vi, ve);

      // Taken branch: 0x100 + (0x10 << 1) = 0x120.
      vi = nop(); vi.valid = 1; vi.branch = 1; vi.zero = 1; vi.pc = 64'h100; vi.imm = 64'h10;
      ve = ezero(); ve.valid = 1; ve.target = 64'h120; ve.pc_src = 1;
      ve.retired = st(2); ve.taken = st(1);
      step(vi, ve);

      // Wrong-path ADD/store: loaded as a bubble, data fields still load.
      vi = nop(); vi.valid = 1; vi.result = 64'h55; vi.rd = 7; vi.rw = 1; vi.mw = 1; vi.pc = 64'h104;
      ve = ezero(); ve.result = 64'h55; ve.rd = 7; ve.target = 64'h104;
      ve.retired = st(2); ve.taken = st(1);
      step(vi, ve);

      // Load instruction resumes normal flow.
      vi = nop(); vi.valid = 1; vi.result = 64'h66; vi.rd = 8; vi.rw = 1; vi.mr = 1; vi.m2r = 1;
      vi.pc = 64'h108;
      ve = ezero(); ve.valid = 1; ve.result = 64'h66; ve.rd = 8; ve.rw = 1; ve.mr = 1; ve.m2r = 1;
      ve.target = 64'h108; ve.retired = st(3); ve.taken = st(1);
      step(vi, ve);

      // Not-taken branch: 0x200 + (4 << 1) = 0x208, no redirect.
      vi = nop(); vi.valid = 1; vi.branch = 1; vi.result = 64'h1; vi.pc = 64'h200; vi.imm = 64'h4;
      ve = ezero(); ve.valid = 1; ve.result = 64'h1; ve.target = 64'h208;
      ve.retired = st(4); ve.taken = st(1);
      step(vi, ve);

      // Taken branch with wrapping target: 0xFFFF_FFFF_FFFF_FFF0 + 0x20 = 0x10.
      vi = nop(); vi.valid = 1; vi.branch = 1; vi.zero = 1; vi.result = 64'h77;
      vi.pc = 64'hFFFF_FFFF_FFFF_FFF0; vi.imm = 64'h10;
      ve = ezero(); ve.valid = 1; ve.result = 64'h77; ve.target = 64'h10; ve.pc_src = 1;
      ve.retired = st(5); ve.taken = st(2);
      step(vi, ve);

      // Three stalled cycles with changing inputs: everything frozen, redirect held.
      for (int k = 0; k < 3; k++) begin
         vi = nop(); vi.stall = 1; vi.valid = 1; vi.rw = 1; vi.rd = 9;
         vi.result = 64'hA + 64'(k); vi.pc = 64'h400 + 64'(k); vi.branch = 1; vi.zero = 1;
         step(vi, ve);
      end

      // Stall and flush together: bubble wins, redirect discarded.
      vi = nop(); vi.stall = 1; vi.flush = 1; vi.valid = 1; vi.result = 64'hDD; vi.rd = 3;
      vi.rw = 1; vi.pc = 64'h300;
      ve = ezero(); ve.result = 64'hDD; ve.rd = 3; ve.target = 64'h300;
      ve.retired = st(5); ve.taken = st(2);
      step(vi, ve);

      // Counter scenario from a fresh reset.
      vi = nop(); vi.reset_n = 0;
      ve = ezero();
      step(vi, ve);

      vi = nop(); vi.valid = 1; vi.result = 64'h1; vi.rd = 1; vi.rw = 1;
      ve = ezero(); ve.valid = 1; ve.result = 64'h1; ve.rd = 1; ve.rw = 1; ve.retired = st(1);
      step(vi, ve);

      vi = nop(); vi.valid = 1; vi.branch = 1; vi.zero = 1; vi.pc = 64'h40; vi.imm = 64'h2;
      ve = ezero(); ve.valid = 1; ve.target = 64'h44; ve.pc_src = 1;
      ve.retired = st(2); ve.taken = st(1);
      step(vi, ve);

      vi = nop(); vi.valid = 1; vi.result = 64'h3; vi.rd = 2; vi.rw = 1; vi.pc = 64'h48;
      ve = ezero(); ve.result = 64'h3; ve.rd = 2; ve.target = 64'h48;
      ve.retired = st(2); ve.taken = st(1);
      step(vi, ve);

      vi = nop(); vi.valid = 1; vi.result = 64'h4; vi.rd = 4; vi.rw = 1; vi.pc = 64'h4C; vi.stall = 1;
      step(vi, ve);

      vi.stall = 0;
      ve = ezero(); ve.valid = 1; ve.result = 64'h4; ve.rd = 4; ve.rw = 1; ve.target = 64'h4C;
      ve.retired = st(3); ve.taken = st(1);
      step(vi, ve);

      // Drain the scoreboard with a bounded wait.
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
